// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_pkg
// Description : Shared types and constants for the AD4008 conversion
//               scheduler: FSM state encoding, default conversion timeout,
//               accumulator width helper and timestamp width.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CONVERT = 2'd2,
        EMIT    = 2'd3
    } sched_state_t;

    localparam int c_DEFAULT_TIMEOUT_CYCLES = 256;
    localparam int c_TS_WIDTH               = 32;

    // Worst-case sum of 2^avg_log2_max full-scale samples needs this many bits.
    function automatic int acc_width(input int adc_width, input int avg_log2_max);
        return adc_width + avg_log2_max;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sched_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_accumulator
// Description : Sample accumulator for the conversion scheduler. Clears on
//               reset or clr, adds din when add_en is high, and presents the
//               sum right-shifted by shift (truncating, unsigned).
// Ports       : clk, reset (sync, active-high), clr, add_en,
//               din [ADC_WIDTH], shift [SHIFT_WIDTH], acc_out [ADC_WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sched_accumulator
    import adc_sched_pkg::*;
#(
    parameter int ADC_WIDTH    = 16,
    parameter int AVG_LOG2_MAX = 4,
    parameter int SHIFT_WIDTH  = $clog2(AVG_LOG2_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   add_en,
    input  logic [ADC_WIDTH-1:0]   din,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [ADC_WIDTH-1:0]   acc_out
);

    localparam int c_ACC_WIDTH = acc_width(ADC_WIDTH, AVG_LOG2_MAX);

    logic [c_ACC_WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_acc <= '0;
        end else if (add_en) begin
            r_acc <= r_acc + c_ACC_WIDTH'(din);
        end
    end

    // Once the window is full the shifted sum always fits in ADC_WIDTH bits.
    assign acc_out = ADC_WIDTH'(r_acc >> shift);

endmodule
`default_nettype wire

// File: rtl/adc_conversion_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_conversion_scheduler
// Description : Drives the AD4008 serial reader. Issues one conv_start pulse
//               per programmable sample period, waits for sample_valid,
//               averages 2^avg_log2 samples and offers the result on a
//               valid/ready stream. Dropped period ticks and conversion
//               timeouts are reported through sticky flags.
// Ports       : clk, reset (sync, active-high), enable, period, avg_log2,
//               conv_start, conv_busy, sample_valid, sample_data,
//               out_valid, out_ready, out_data, overrun, timeout_err
//               [out_timestamp when ADC_SCHED_TIMESTAMP_EN is defined]
// Options     : ADC_SCHED_TIMESTAMP_EN - adds a 32-bit free-running cycle
//               counter captured at the first conv_start of each window.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_conversion_scheduler
    import adc_sched_pkg::*;
#(
    parameter int ADC_WIDTH      = 16,
    parameter int PERIOD_WIDTH   = 16,
    parameter int AVG_LOG2_MAX   = 4,
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    parameter int AVG_WIDTH      = $clog2(AVG_LOG2_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [AVG_WIDTH-1:0]    avg_log2,
    output logic                    conv_start,
    input  logic                    conv_busy,
    input  logic                    sample_valid,
    input  logic [ADC_WIDTH-1:0]    sample_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADC_WIDTH-1:0]    out_data,
`ifdef ADC_SCHED_TIMESTAMP_EN
    output logic [c_TS_WIDTH-1:0]   out_timestamp,
`endif
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int c_CNT_WIDTH = AVG_LOG2_MAX + 1;
    localparam int c_TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t            r_state;
    sched_state_t            w_next_state;
    logic [PERIOD_WIDTH-1:0] r_period_q;
    logic [PERIOD_WIDTH-1:0] r_pcnt;
    logic [AVG_WIDTH-1:0]    r_avg_q;
    logic [c_CNT_WIDTH-1:0]  r_count;
    logic [c_CNT_WIDTH-1:0]  w_target;
    logic [c_TMO_WIDTH-1:0]  r_tmo;
    logic                    r_overrun;
    logic                    r_timeout;

    logic                    w_tick;
    logic                    w_latch;
    logic                    w_conv_start;
    logic                    w_set_ovr;
    logic                    w_set_tmo;
    logic                    w_acc_clr;
    logic                    w_acc_add;
    logic [PERIOD_WIDTH-1:0] w_period_clamped;
    logic [AVG_WIDTH-1:0]    w_avg_clamped;
    logic [ADC_WIDTH-1:0]    w_acc_shifted;

    assign w_period_clamped = (period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : period;
    assign w_avg_clamped    = (avg_log2 > AVG_WIDTH'(AVG_LOG2_MAX))
                            ? AVG_WIDTH'(AVG_LOG2_MAX) : avg_log2;

    // Counter is held at 0 in IDLE and then counts 1..period_q, so the first
    // tick lands period_q cycles after leaving IDLE and every period_q after.
    assign w_tick   = (r_state != IDLE) && (r_pcnt == r_period_q);
    assign w_target = c_CNT_WIDTH'(1) << r_avg_q;

    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE)) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= PERIOD_WIDTH'(1);
        end else begin
            r_pcnt <= r_pcnt + PERIOD_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_conv_start = 1'b0;
        w_set_ovr    = 1'b0;
        w_set_tmo    = 1'b0;
        w_acc_clr    = 1'b0;
        w_acc_add    = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next_state = WAIT;
                    w_latch      = 1'b1;
                    w_acc_clr    = 1'b1;
                end
            end
            WAIT: begin
                if (w_tick) begin
                    if (!conv_busy) begin
                        w_conv_start = 1'b1;
                        w_next_state = CONVERT;
                    end else begin
                        w_set_ovr = 1'b1;
                    end
                end
            end
            CONVERT: begin
                w_set_ovr = w_tick;
                if (sample_valid) begin
                    w_acc_add = 1'b1;
                    if ((r_count + c_CNT_WIDTH'(1)) == w_target) begin
                        w_next_state = EMIT;
                    end else begin
                        w_next_state = WAIT;
                    end
                end else if (r_tmo == c_TMO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    // Partial window is kept; the next tick retries.
                    w_set_tmo    = 1'b1;
                    w_next_state = WAIT;
                end
            end
            EMIT: begin
                w_set_ovr = w_tick;
                if (out_ready) begin
                    w_acc_clr    = 1'b1;
                    w_next_state = WAIT;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Dropping enable abandons whatever is in flight, including a
        // result waiting for its handshake.
        if (!enable) begin
            w_next_state = IDLE;
            w_latch      = 1'b0;
            w_conv_start = 1'b0;
            w_set_ovr    = 1'b0;
            w_set_tmo    = 1'b0;
            w_acc_add    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Config capture, sample count, timeout counter, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_q <= '0;
            r_avg_q    <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_period_q <= w_period_clamped;
                r_avg_q    <= w_avg_clamped;
            end

            if (w_acc_clr) begin
                r_count <= '0;
            end else if (w_acc_add) begin
                r_count <= r_count + c_CNT_WIDTH'(1);
            end

            if (w_latch) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                if (w_set_ovr) begin
                    r_overrun <= 1'b1;
                end
                if (w_set_tmo) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state != CONVERT)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + c_TMO_WIDTH'(1);
        end
    end

    adc_sched_accumulator #(
        .ADC_WIDTH    (ADC_WIDTH),
        .AVG_LOG2_MAX (AVG_LOG2_MAX),
        .SHIFT_WIDTH  (AVG_WIDTH)
    ) u_accumulator (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_acc_clr),
        .add_en  (w_acc_add),
        .din     (sample_data),
        .shift   (r_avg_q),
        .acc_out (w_acc_shifted)
    );

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [c_TS_WIDTH-1:0] r_ts;
    logic [c_TS_WIDTH-1:0] r_ts_cap;

    // Only the first conversion of a window (count still 0) stamps it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts     <= '0;
            r_ts_cap <= '0;
        end else begin
            r_ts <= r_ts + c_TS_WIDTH'(1);
            if (w_conv_start && (r_count == '0)) begin
                r_ts_cap <= r_ts;
            end
        end
    end

    assign out_timestamp = r_ts_cap;
`endif

    // Accumulator and shift are both stable during EMIT, so out_data holds
    // until the handshake without an extra holding register.
    assign conv_start  = w_conv_start;
    assign out_valid   = (r_state == EMIT);
    assign out_data    = out_valid ? w_acc_shifted : '0;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire
